// File: rtl/vx_bank_req_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : vx_bank_req_sched                                                |
// | Brief   : Per-bank fill/replay/core arbiter feeding a one-entry issue stage |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+

module vx_bank_req_sched #(
  parameter int CACHE_ID     = 0,
  parameter int BANK_ID      = 0,
  parameter int MSHR_SIZE    = 8,
  parameter int STARVE_LIMIT = 8,
  parameter int DRAIN_MIN    = 2,
  localparam int MSHR_ADDR_WIDTH = (MSHR_SIZE > 1) ? $clog2(MSHR_SIZE) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fill_valid,
  output logic                       fill_ready,
  input  logic [MSHR_ADDR_WIDTH-1:0] fill_id,
  input  logic                       replay_valid,
  output logic                       replay_ready,
  input  logic [MSHR_ADDR_WIDTH-1:0] replay_id,
  input  logic                       core_valid,
  output logic                       core_ready,
  input  logic                       mshr_alloc_rdy,
  output logic                       pipe_valid,
  output logic [1:0]                 pipe_src,
  output logic [MSHR_ADDR_WIDTH-1:0] pipe_mshr_id,
  input  logic                       pipe_ready
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int DW = $clog2(DRAIN_MIN + 1);

  localparam logic [SW-1:0] c_STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [DW-1:0] c_DRAIN_LOAD = DW'(DRAIN_MIN);

  localparam logic [1:0] c_SRC_NONE   = 2'b00;
  localparam logic [1:0] c_SRC_FILL   = 2'b01;
  localparam logic [1:0] c_SRC_REPLAY = 2'b10;
  localparam logic [1:0] c_SRC_CORE   = 2'b11;

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_DRAIN  = 1'b1
  } state_t;

  state_t                     r_state;
  logic [DW-1:0]              r_drain_cnt;
  logic [SW-1:0]              r_starve_cnt;
  logic                       r_pipe_valid;
  logic [1:0]                 r_pipe_src;
  logic [MSHR_ADDR_WIDTH-1:0] r_pipe_mshr_id;

  logic w_adv;
  logic w_core_elig;
  logic w_starved;
  logic w_grant_fill;
  logic w_grant_replay;
  logic w_grant_core;
  logic w_in_drain;

  // Grants are suppressed during reset so nothing is handshaken into a stage being cleared.
  always_comb begin
    w_adv          = !r_pipe_valid || pipe_ready;
    w_in_drain     = (r_state == ST_DRAIN);
    w_core_elig    = core_valid && mshr_alloc_rdy && !w_in_drain;
    w_starved      = w_core_elig && (r_starve_cnt == c_STARVE_MAX);
    w_grant_fill   = 1'b0;
    w_grant_replay = 1'b0;
    w_grant_core   = 1'b0;
    if (w_adv && !reset) begin
      if (w_starved)
        w_grant_core = 1'b1;
      else if (fill_valid)
        w_grant_fill = 1'b1;
      else if (replay_valid)
        w_grant_replay = 1'b1;
      else if (w_core_elig)
        w_grant_core = 1'b1;
    end
  end

  assign fill_ready   = w_grant_fill;
  assign replay_ready = w_grant_replay;
  assign core_ready   = w_grant_core;

  assign pipe_valid   = r_pipe_valid;
  assign pipe_src     = r_pipe_src;
  assign pipe_mshr_id = r_pipe_mshr_id;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pipe_valid   <= 1'b0;
      r_pipe_src     <= c_SRC_NONE;
      r_pipe_mshr_id <= '0;
    end else if (w_grant_fill) begin
      r_pipe_valid   <= 1'b1;
      r_pipe_src     <= c_SRC_FILL;
      r_pipe_mshr_id <= fill_id;
    end else if (w_grant_replay) begin
      r_pipe_valid   <= 1'b1;
      r_pipe_src     <= c_SRC_REPLAY;
      r_pipe_mshr_id <= replay_id;
    end else if (w_grant_core) begin
      r_pipe_valid   <= 1'b1;
      r_pipe_src     <= c_SRC_CORE;
      r_pipe_mshr_id <= '0;
    end else if (pipe_ready) begin
      r_pipe_valid   <= 1'b0;
      r_pipe_src     <= c_SRC_NONE;
      r_pipe_mshr_id <= '0;
    end
  end

  // Only cycles where the stage could have advanced count as a lost arbitration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (w_grant_core || !core_valid) begin
      r_starve_cnt <= '0;
    end else if (w_adv && (r_starve_cnt != c_STARVE_MAX)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // DRAIN keeps core requests out until pending replays for the filled line are gone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_NORMAL;
      r_drain_cnt <= '0;
    end else if (w_grant_fill) begin
      r_state     <= ST_DRAIN;
      r_drain_cnt <= c_DRAIN_LOAD;
    end else if (r_state == ST_DRAIN) begin
      if ((r_drain_cnt == '0) && !replay_valid && !fill_valid)
        r_state <= ST_NORMAL;
      else if (r_drain_cnt != '0)
        r_drain_cnt <= r_drain_cnt - 1'b1;
    end
  end

  a_one_grant : assert property (@(posedge clk) disable iff (reset)
    $onehot0({fill_ready, replay_ready, core_ready}))
    else $error("vx_bank_req_sched c%0d b%0d: multiple grants", CACHE_ID, BANK_ID);

  a_grant_needs_adv : assert property (@(posedge clk) disable iff (reset)
    (fill_ready || replay_ready || core_ready) |-> w_adv)
    else $error("vx_bank_req_sched c%0d b%0d: grant while stalled", CACHE_ID, BANK_ID);

endmodule

`default_nettype wire

// File: tb/tb_vx_bank_req_sched.sv
`default_nettype none
// Directed bench for vx_bank_req_sched: cycle model compared every cycle plus literal spot checks.

module tb_vx_bank_req_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fill_valid = 1'b0, replay_valid = 1'b0, core_valid = 1'b0;
  logic       mshr_alloc_rdy = 1'b0, pipe_ready = 1'b1;
  logic [2:0] fill_id = '0, replay_id = '0;
  logic       fill_ready, replay_ready, core_ready, pipe_valid;
  logic [1:0] pipe_src;
  logic [2:0] pipe_mshr_id;

  int n_vec = 0;
  int n_mis = 0;

  vx_bank_req_sched #(
    .CACHE_ID(0), .BANK_ID(0), .MSHR_SIZE(8), .STARVE_LIMIT(4), .DRAIN_MIN(2)
  ) dut (
    .clk(clk), .reset(reset),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_id(fill_id),
    .replay_valid(replay_valid), .replay_ready(replay_ready), .replay_id(replay_id),
    .core_valid(core_valid), .core_ready(core_ready), .mshr_alloc_rdy(mshr_alloc_rdy),
    .pipe_valid(pipe_valid), .pipe_src(pipe_src), .pipe_mshr_id(pipe_mshr_id),
    .pipe_ready(pipe_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: what is in the stage, how long core has lost, and the fill drain window.
  int m_pv = 0, m_src = 0, m_id = 0, m_starve = 0, m_drain_left = 0;
  bit m_draining = 0;

  // Winner this cycle: 0 none, 1 fill, 2 replay, 3 core.
  function automatic int pick();
    bit can_move, core_ok;
    can_move = (m_pv == 0) || pipe_ready;
    core_ok  = core_valid && mshr_alloc_rdy && !m_draining;
    if (!can_move) return 0;
    if (core_ok && m_starve == 4) return 3;
    if (fill_valid) return 1;
    if (replay_valid) return 2;
    if (core_ok) return 3;
    return 0;
  endfunction

  always begin : compare
    int w;
    @(negedge clk);
    #4;
    if (!reset) begin
      w = pick();
      chk("fill_ready", {31'b0, fill_ready}, (w == 1) ? 1 : 0);
      chk("replay_ready", {31'b0, replay_ready}, (w == 2) ? 1 : 0);
      chk("core_ready", {31'b0, core_ready}, (w == 3) ? 1 : 0);
      chk("pipe_valid", {31'b0, pipe_valid}, m_pv);
      chk("pipe_src", {30'b0, pipe_src}, m_src);
      chk("pipe_mshr_id", {29'b0, pipe_mshr_id}, m_id);
      chk("starve_cnt", 32'(dut.r_starve_cnt), m_starve);
      chk("in_drain", {31'b0, dut.w_in_drain}, m_draining);
      chk("drain_cnt", 32'(dut.r_drain_cnt), m_drain_left);
    end
    @(posedge clk);
    if (reset) begin
      m_pv = 0; m_src = 0; m_id = 0; m_starve = 0; m_drain_left = 0; m_draining = 0;
    end else begin
      w = pick();
      if (w != 0) begin
        m_pv = 1; m_src = w;
        m_id = (w == 1) ? int'(fill_id) : (w == 2) ? int'(replay_id) : 0;
      end else if (pipe_ready) begin
        m_pv = 0; m_src = 0; m_id = 0;
      end
      if (w == 3 || !core_valid) m_starve = 0;
      else if (((m_pv == 0) || pipe_ready || w != 0) && m_starve < 4) m_starve++;
      if (w == 1) begin
        m_draining = 1; m_drain_left = 2;
      end else if (m_draining) begin
        if (m_drain_left == 0 && !replay_valid && !fill_valid) m_draining = 0;
        else if (m_drain_left > 0) m_drain_left--;
      end
    end
  end

  task automatic cyc(input logic fv, input logic [2:0] fid, input logic rv, input logic [2:0] rid,
                     input logic cv, input logic mr, input logic pr);
    @(negedge clk);
    fill_valid = fv; fill_id = fid; replay_valid = rv; replay_id = rid;
    core_valid = cv; mshr_alloc_rdy = mr; pipe_ready = pr;
    #4;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst pipe_valid", {31'b0, pipe_valid}, 0);
    chk("rst pipe_src", {30'b0, pipe_src}, 0);
    @(negedge clk);
    reset = 1'b0;

    // Priority and fill->replay drain window
    cyc(1, 3, 1, 5, 1, 1, 1);
    chk("t2 fill first", {31'b0, fill_ready}, 1);
    cyc(0, 0, 1, 5, 1, 1, 1);
    chk("t2 replay second", {31'b0, replay_ready}, 1);
    chk("t2 fill id issued", {29'b0, pipe_mshr_id}, 3);
    cyc(0, 0, 0, 0, 1, 1, 1);
    chk("t2 core blocked a", {31'b0, core_ready}, 0);
    chk("t2 replay src", {30'b0, pipe_src}, 2);
    cyc(0, 0, 0, 0, 1, 1, 1);
    chk("t2 core blocked b", {31'b0, core_ready}, 0);
    cyc(0, 0, 0, 0, 1, 1, 1);
    chk("t2 core granted", {31'b0, core_ready}, 1);
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("t2 core src", {30'b0, pipe_src}, 3);
    chk("t2 core id", {29'b0, pipe_mshr_id}, 0);

    // Backpressure hold, then no-bubble release
    cyc(0, 0, 1, 2, 0, 1, 1);
    chk("t3 replay grant", {31'b0, replay_ready}, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 6, 0, 1, 0);
      chk("t3 held no ready", {31'b0, replay_ready}, 0);
      chk("t3 held id", {29'b0, pipe_mshr_id}, 2);
    end
    cyc(0, 0, 1, 6, 0, 1, 1);
    chk("t3 release grant", {31'b0, replay_ready}, 1);
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("t3 back-to-back id", {29'b0, pipe_mshr_id}, 6);

    // Starvation override after four lost cycles
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 1, 1, 1, 1);
      chk("t4 replay wins", {31'b0, replay_ready}, 1);
    end
    cyc(0, 0, 1, 1, 1, 1, 1);
    chk("t4 core forced", {31'b0, core_ready}, 1);
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("t4 starve cleared", 32'(dut.r_starve_cnt), 0);

    // MSHR full blocks core only
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 1, 0, 1);
      chk("t5 core blocked", {31'b0, core_ready}, 0);
    end
    cyc(0, 0, 0, 0, 1, 1, 1);
    chk("t5 core on alloc", {31'b0, core_ready}, 1);
    cyc(0, 0, 0, 0, 0, 1, 1);

    // Second fill inside DRAIN reloads the window
    cyc(1, 4, 0, 0, 0, 1, 1);
    chk("t6 fill a", {31'b0, fill_ready}, 1);
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("t6 drain loaded", 32'(dut.r_drain_cnt), 2);
    cyc(1, 7, 0, 0, 0, 1, 1);
    chk("t6 drain at one", 32'(dut.r_drain_cnt), 1);
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("t6 drain reloaded", 32'(dut.r_drain_cnt), 2);
    chk("t6 still drain", {31'b0, dut.w_in_drain}, 1);
    chk("t6 fill id", {29'b0, pipe_mshr_id}, 7);
    repeat (3) cyc(0, 0, 0, 0, 0, 1, 1);
    chk("t6 back to normal", {31'b0, dut.w_in_drain}, 0);

    // Async reset mid-cycle with a staged request
    cyc(1, 5, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("t1 staged", {31'b0, pipe_valid}, 1);
    chk("t1 starve nonzero", 32'(dut.r_starve_cnt), 1);
    @(posedge clk);
    #2;
    reset = 1'b1; fill_valid = 1'b1; pipe_ready = 1'b1;
    #1;
    chk("t1 pipe_valid", {31'b0, pipe_valid}, 0);
    chk("t1 fill_ready", {31'b0, fill_ready}, 0);
    chk("t1 starve", 32'(dut.r_starve_cnt), 0);
    chk("t1 mshr_id", {29'b0, pipe_mshr_id}, 0);
    chk("t1 in_drain", {31'b0, dut.w_in_drain}, 0);
    @(negedge clk);
    fill_valid = 1'b0; core_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) cyc(0, 0, 0, 0, 0, 1, 1);
    chk("t1 no replay after reset", {31'b0, pipe_valid}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
